// File: rtl/lenet_sequencer_pkg.sv
// Shared types and widths for the LeNet launch sequencer.
package lenet_pkg;

  localparam int LENET_DIGIT_W = 4;
  localparam int LENET_CNT_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE,
    LATCH
  } lenet_seq_state_t;

endpackage

// File: rtl/lenet_sequencer_if.sv
// Signal bundle between the sequencer, the core/LeNet side (master) and the sequencer itself (slave).
interface lenet_sequencer_if;
  import lenet_pkg::*;

  logic                     enable;
  logic                     data_ready;
  logic                     lenet_ready;
  logic [LENET_DIGIT_W-1:0] lenet_digit;
  logic                     lenet_go;
  logic                     busy;
  logic [LENET_DIGIT_W-1:0] digit_out;
  logic                     digit_valid;
  logic                     timeout_err;
  logic [LENET_CNT_W-1:0]   drop_count;
  logic [LENET_CNT_W-1:0]   infer_count;

  modport master (
    output enable, data_ready, lenet_ready, lenet_digit,
    input  lenet_go, busy, digit_out, digit_valid, timeout_err, drop_count, infer_count
  );

  modport slave (
    input  enable, data_ready, lenet_ready, lenet_digit,
    output lenet_go, busy, digit_out, digit_valid, timeout_err, drop_count, infer_count
  );

endinterface

// File: rtl/lenet_sequencer_sync_edge.sv
// Multi-flop synchroniser with a registered rising-edge pulse on the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;
  logic         r_q_d;
  logic         r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_q_d  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], d};
      r_q_d  <= r_sync[N-1];
      r_rise <= r_sync[N-1] & ~r_q_d;
    end
  end

  assign q    = r_sync[N-1];
  assign rise = r_rise;

endmodule

// File: rtl/lenet_sequencer.sv
// Launches one LeNet inference per input frame, with a one-deep pending queue and watchdogs.
// Optional LENET_STABLE_EN: publish a digit only after STABLE_COUNT identical consecutive results.
module lenet_sequencer
  import lenet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int ACK_CYCLES     = 16,
  parameter int STABLE_COUNT   = 3,
  parameter int SYNC_STAGES    = 2
) (
  input logic               clk,
  input logic               rst,
  lenet_sequencer_if.slave  bus
);

  function automatic logic [LENET_CNT_W-1:0] sat_inc(input logic [LENET_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic w_frame_rise;
  logic w_en;

  sync_edge #(.STAGES(SYNC_STAGES)) u_frame_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.data_ready),
    .q   (),
    .rise(w_frame_rise)
  );

  sync_edge #(.STAGES(2)) u_enable_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.enable),
    .q   (w_en),
    .rise()
  );

  lenet_seq_state_t         r_state;
  lenet_seq_state_t         w_state_next;
  logic                     r_pending;
  logic [31:0]              r_wd;
  logic                     r_tmo;
  logic [LENET_CNT_W-1:0]   r_drop;
  logic [LENET_CNT_W-1:0]   r_infer;
  logic [LENET_DIGIT_W-1:0] r_digit;
  logic                     r_valid;

  logic w_ev;
  logic w_pend_eff;
  logic w_pend_next;
  logic w_drop;
  logic w_tmo;
  logic w_latch;
  logic w_go;
  logic w_busy;
  logic w_publish;

  // Disabling run mode masks new frames and flushes any queued one.
  assign w_ev       = w_frame_rise & w_en;
  assign w_pend_eff = r_pending & w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = w_pend_eff;
    w_drop       = 1'b0;
    w_tmo        = 1'b0;
    w_latch      = 1'b0;
    w_go         = 1'b0;
    w_busy       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ev || w_pend_eff) begin
          w_state_next = LAUNCH;
          w_pend_next  = 1'b0;
          w_drop       = w_ev & w_pend_eff;
        end
      end
      LAUNCH: begin
        w_go         = 1'b1;
        w_busy       = 1'b1;
        w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        w_busy = 1'b1;
        if (!bus.lenet_ready) begin
          w_state_next = WAIT_DONE;
        end else if (r_wd >= 32'(ACK_CYCLES)) begin
          w_state_next = IDLE;
          w_tmo        = 1'b1;
        end
      end
      WAIT_DONE: begin
        w_busy = 1'b1;
        if (bus.lenet_ready) begin
          w_state_next = LATCH;
        end else if (r_wd >= 32'(TIMEOUT_CYCLES)) begin
          w_state_next = IDLE;
          w_tmo        = 1'b1;
        end
      end
      LATCH: begin
        w_latch      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (r_state != IDLE && w_ev) begin
      if (w_pend_eff) w_drop      = 1'b1;
      else            w_pend_next = 1'b1;
    end
  end

`ifdef LENET_STABLE_EN
  localparam int RUN_W = $clog2(STABLE_COUNT + 1);

  logic [RUN_W-1:0]         r_run;
  logic [LENET_DIGIT_W-1:0] r_prev;
  logic [RUN_W-1:0]         w_run_next;

  always_comb begin
    w_run_next = RUN_W'(1);
    if (r_run != '0 && bus.lenet_digit == r_prev)
      w_run_next = (r_run >= RUN_W'(STABLE_COUNT)) ? r_run : r_run + 1'b1;
  end

  assign w_publish = w_latch && (w_run_next >= RUN_W'(STABLE_COUNT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run  <= '0;
      r_prev <= '0;
    end else if (w_latch) begin
      r_run  <= w_run_next;
      r_prev <= bus.lenet_digit;
    end else if (w_tmo) begin
      r_run  <= '0;
    end
  end
`else
  assign w_publish = w_latch;
`endif

  // Watchdog counts cycles since LAUNCH; shared by the ack and completion limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_wd      <= '0;
      r_tmo     <= 1'b0;
      r_drop    <= '0;
      r_infer   <= '0;
      r_digit   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      if (w_state_next == LAUNCH) r_wd <= '0;
      else if (r_state != IDLE)   r_wd <= r_wd + 1'b1;
      if (w_tmo)  r_tmo  <= 1'b1;
      if (w_drop) r_drop <= sat_inc(r_drop);
      if (w_latch) r_infer <= r_infer + 1'b1;
      if (w_publish) begin
        r_digit <= bus.lenet_digit;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.lenet_go    = w_go;
  assign bus.busy        = w_busy;
  assign bus.digit_out   = r_digit;
  assign bus.digit_valid = r_valid;
  assign bus.timeout_err = r_tmo;
  assign bus.drop_count  = r_drop;
  assign bus.infer_count = r_infer;

endmodule

// File: tb/tb_lenet_sequencer.sv
// Directed bench for lenet_sequencer: a LeNet engine model answers lenet_go, and a monitor
// checks each end-of-inference snapshot against a queue of expected results.
module tb_lenet_sequencer;

  localparam int TMO    = 1000;
  localparam int ACK    = 16;
  localparam int STABLE = 3;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lenet_sequencer_if bus();

  lenet_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .ACK_CYCLES    (ACK),
    .STABLE_COUNT  (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int digit;
    int valid;
    int infer;
    int drop;
    int tmo;
  } exp_t;

  exp_t sbq[$];
  int   digq[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   go_cnt = 0;

  int m_mode = 0;   // 0 normal, 1 never acknowledges, 2 acknowledges but never finishes
  int m_done = 20;
  bit m_active = 1'b0;

  int e_digit = 0, e_valid = 0, e_infer = 0, e_drop = 0, e_tmo = 0, e_run = 0, e_prev = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.digit = e_digit; e.valid = e_valid; e.infer = e_infer; e.drop = e_drop; e.tmo = e_tmo;
    sbq.push_back(e);
  endtask

  // Queue one LeNet result and the snapshot it should produce.
  task automatic expect_run(input int d);
    digq.push_back(d);
    e_infer = (e_infer + 1) % 256;
`ifdef LENET_STABLE_EN
    if (e_run != 0 && d == e_prev) begin
      if (e_run < STABLE) e_run++;
    end else begin
      e_run = 1;
    end
    e_prev = d;
    if (e_run >= STABLE) begin
      e_digit = d;
      e_valid = 1;
    end
`else
    e_digit = d;
    e_valid = 1;
`endif
    push_exp();
  endtask

  task automatic expect_timeout();
    e_tmo = 1;
    e_run = 0;
    push_exp();
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.data_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raise data_ready, wait for the launch, then count cycles until busy drops.
  task automatic frame_timed(output int lat);
    int n;
    n = 0;
    @(negedge clk);
    bus.data_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.lenet_go && n < 50);
    bus.data_ready = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.busy && lat < 3000);
  endtask

  task automatic wait_idle(input int budget);
    int n, quiet;
    n = 0;
    quiet = 0;
    while (quiet < 8 && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.busy || m_active) quiet = 0;
      else                      quiet++;
    end
    if (quiet < 8) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
  endtask

  // LeNet engine model: drops ready 2 cycles after go, raises it m_done cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.lenet_go && m_mode != 1) begin
        m_active = 1'b1;
        repeat (2) @(negedge clk);
        bus.lenet_ready = 1'b0;
        if (m_mode == 0) begin
          repeat (m_done) @(negedge clk);
          bus.lenet_digit = (digq.size() > 0) ? 4'(digq.pop_front()) : 4'd0;
          bus.lenet_ready = 1'b1;
        end
        m_active = 1'b0;
      end
    end
  end

  // Monitor: one snapshot per busy fall, taken the cycle after so published digits have settled.
  initial begin
    bit   pb, samp;
    int   gw;
    exp_t e;
    pb = 1'b0; samp = 1'b0; gw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0; samp = 1'b0; gw = 0;
      end else begin
        if (samp) begin
          samp = 1'b0;
          if (sbq.size() == 0) begin
            chk("sb_unexpected_result", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("digit_out",   int'(bus.digit_out),   e.digit);
            chk("digit_valid", int'(bus.digit_valid), e.valid);
            chk("infer_count", int'(bus.infer_count), e.infer);
            chk("drop_count",  int'(bus.drop_count),  e.drop);
            chk("timeout_err", int'(bus.timeout_err), e.tmo);
          end
        end
        if (pb && !bus.busy) samp = 1'b1;
        if (bus.lenet_go) begin
          go_cnt++;
          gw++;
        end else if (gw != 0) begin
          chk("go_width", gw, 1);
          gw = 0;
        end
        pb = bus.busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, lat;
    int seq[5];
    seq = '{3, 3, 5, 5, 5};
    bus.enable      = 1'b0;
    bus.data_ready  = 1'b0;
    bus.lenet_ready = 1'b1;
    bus.lenet_digit = 4'd0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_go",    int'(bus.lenet_go),    0);
    chk("rst_busy",  int'(bus.busy),        0);
    chk("rst_digit", int'(bus.digit_out),   0);
    chk("rst_valid", int'(bus.digit_valid), 0);
    chk("rst_tmo",   int'(bus.timeout_err), 0);
    chk("rst_drop",  int'(bus.drop_count),  0);
    chk("rst_infer", int'(bus.infer_count), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame: launch latency is sync stages + edge register + LAUNCH.
    m_mode = 0; m_done = 500;
    expect_run(7);
    bus.data_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.lenet_go && n < 50);
    chk("go_latency", n, SYNC + 2);
    repeat (3) @(negedge clk);
    bus.data_ready = 1'b0;
    wait_idle(1000);
    chk("go_count_single", go_cnt, 1);

    // Three frames during one inference: one queued, one dropped.
    m_done = 60;
    e_drop = 1;
    expect_run(1);
    expect_run(2);
    repeat (3) pulse_frame();
    wait_idle(1000);
    chk("go_count_pending", go_cnt, 3);

    // Completion watchdog trips when its count reaches TMO; the flag registers one edge later.
    m_mode = 2;
    expect_timeout();
    frame_timed(lat);
    chk("wd_latency", lat, TMO + 1);
    chk("wd_flag", int'(bus.timeout_err), 1);
    bus.lenet_ready = 1'b1;
    wait_idle(100);

    // Ack watchdog: LAUNCH cycle plus ACK cycles in WAIT_ACK.
    m_mode = 1;
    expect_timeout();
    frame_timed(lat);
    chk("ack_latency", lat, ACK + 1);
    chk("ack_busy", int'(bus.busy), 0);
    wait_idle(100);
    m_mode = 0; m_done = 20;
    expect_run(4);
    pulse_frame();
    wait_idle(200);
    chk("go_count_after_tmo", go_cnt, 6);

    // Result sequence 3,3,5,5,5.
    foreach (seq[i]) begin
      expect_run(seq[i]);
      pulse_frame();
      wait_idle(200);
    end
    chk("seq_digit", int'(bus.digit_out), 5);
    chk("go_count_seq", go_cnt, 11);

    // Enable falls mid-inference: queued frame flushed, later frames ignored and not dropped.
    m_done = 60;
    expect_run(6);
    pulse_frame();
    pulse_frame();
    bus.enable = 1'b0;
    repeat (4) @(negedge clk);
    pulse_frame();
    wait_idle(300);
    chk("go_count_disable", go_cnt, 12);
    chk("drop_disable", int'(bus.drop_count), 1);
    bus.enable = 1'b1;
    repeat (5) @(negedge clk);

    // Reset during WAIT_DONE: outputs clear at once and the late completion is ignored.
    m_done = 300;
    digq.push_back(9);
    pulse_frame();
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  int'(bus.busy),        0);
    chk("arst_go",    int'(bus.lenet_go),    0);
    chk("arst_digit", int'(bus.digit_out),   0);
    chk("arst_valid", int'(bus.digit_valid), 0);
    chk("arst_tmo",   int'(bus.timeout_err), 0);
    chk("arst_drop",  int'(bus.drop_count),  0);
    chk("arst_infer", int'(bus.infer_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(600);
    chk("post_rst_infer", int'(bus.infer_count), 0);
    chk("post_rst_valid", int'(bus.digit_valid), 0);
    chk("post_rst_go",    go_cnt, 13);

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
